jtopl_reg_chn: RTL and testbench

Parametrised channel-configuration store for the JTOPL operator pipeline: GROUPS circulating shift registers of DEPTH entries each, CHCSRW bits wide, rotating in lock-step with the slot sequencer. Unlike the fixed three-group store, it owns its own channel position counter and exposes a CPU-side single-outstanding write/read port that commits when the target channel reaches the head. It also carries the generalised rhythm key-on CSR and the rhythm output-enable flag. It sits between the register-write decoder and the phase/envelope generators.

---
 rtl/jtopl_reg_chn_if.sv | 25 ++
 rtl/jtopl_reg_chn.sv | 156 +++++++++++++++
 tb/tb_jtopl_reg_chn.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jtopl_reg_chn_if.sv
// CPU-side request/response port of the channel configuration store.
// master: issues single-outstanding write/read requests.
// slave : the store; reports busy, a one-cycle ack on commit, and read data.
interface jtopl_reg_chn_if #(
  parameter int PW     = 4,
  parameter int CHCSRW = 10
);
  logic              cpu_wr;
  logic              cpu_rd;
  logic [PW-1:0]     cpu_ch;
  logic [CHCSRW-1:0] cpu_din;
  logic              cpu_busy;
  logic              cpu_ack;
  logic [CHCSRW-1:0] cpu_dout;

  modport master (
    output cpu_wr, cpu_rd, cpu_ch, cpu_din,
    input  cpu_busy, cpu_ack, cpu_dout
  );

  modport slave (
    input  cpu_wr, cpu_rd, cpu_ch, cpu_din,
    output cpu_busy, cpu_ack, cpu_dout
  );
endinterface

// File: rtl/jtopl_reg_chn.sv
// Channel configuration store for the operator pipeline.
// GROUPS circulating shift registers of DEPTH entries rotate in lock-step with
// an internal channel position counter; channel c sits in group c mod GROUPS
// and is presented on chcfg when the counter reaches c. A single-outstanding
// CPU request commits when its channel reaches the head. Also holds the
// rotating rhythm key-on CSR and the rhythm output-enable flag.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   cen             clock enable for counter, groups, rhythm CSR and commit
//   rhy_en, rhy_kon rhythm enable and key-on bits {BD,SD,TOM,TC,HH}
//   cpu             request port (slave modport of jtopl_reg_chn_if)
//   chcfg           configuration of the channel at head (combinational)
//   ch_idx, zero    channel at head, high when it is channel 0
//   rhy_oen         rhythm operator output enable
//   rhyon_csr       MSB of the rhythm CSR
//
// Request FSM:
//   state   | meaning
//   ST_IDLE | no request outstanding, strobes are accepted
//   ST_WAIT | request latched, waiting for its channel to reach head
module jtopl_reg_chn #(
  parameter int CHCSRW  = 10,
  parameter int GROUPS  = 3,
  parameter int DEPTH   = 3,
  parameter int RHY_POS = 11,
  parameter int PW      = ((GROUPS*DEPTH) > 1) ? $clog2(GROUPS*DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              rhy_en,
  input  logic [4:0]        rhy_kon,
  jtopl_reg_chn_if.slave    cpu,
  output logic [CHCSRW-1:0] chcfg,
  output logic [PW-1:0]     ch_idx,
  output logic              zero,
  output logic              rhy_oen,
  output logic              rhyon_csr
);
  localparam int              NCH       = GROUPS*DEPTH;
  localparam int              GW        = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [PW-1:0]   LAST_POS  = PW'(NCH-1);
  localparam logic [PW:0]     NCH_W     = (PW+1)'(NCH);
  localparam logic [GW-1:0]   LAST_GRP  = GW'(GROUPS-1);
  localparam logic [31:0]     RHY_POS_W = 32'(RHY_POS);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     pos;
  logic [GW-1:0]     grp;
  logic [CHCSRW-1:0] mem [GROUPS][DEPTH];
  logic              lat_wr;
  logic [PW-1:0]     lat_ch;
  logic [CHCSRW-1:0] lat_din;
  logic [5:0]        rhy_csr;
  logic              capture, commit, ch_ok, at_last, at_rhy;

  assign ch_ok   = ({1'b0, cpu.cpu_ch} < NCH_W);
  assign at_last = (pos == LAST_POS);
  assign at_rhy  = (32'(pos) == RHY_POS_W);

  assign chcfg        = mem[grp][0];
  assign ch_idx       = pos;
  assign rhyon_csr    = rhy_csr[5];
  assign cpu.cpu_busy = (state == ST_WAIT);

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    commit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((cpu.cpu_wr || cpu.cpu_rd) && ch_ok) begin
          capture  = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A request captured while its channel is at head only commits on
        // the next visit, because capture and commit are exclusive states.
        if (cen && pos == lat_ch) begin
          commit   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      lat_wr       <= 1'b0;
      lat_ch       <= '0;
      lat_din      <= '0;
      cpu.cpu_ack  <= 1'b0;
      cpu.cpu_dout <= '0;
    end else begin
      state       <= state_nx;
      cpu.cpu_ack <= commit;
      if (capture) begin
        lat_wr  <= cpu.cpu_wr;
        lat_ch  <= cpu.cpu_ch;
        lat_din <= cpu.cpu_din;
      end
      if (commit && !lat_wr) cpu.cpu_dout <= chcfg;
    end
  end

  // Position counter and active group advance together; NCH is a multiple of
  // GROUPS so both wrap on the same cen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos  <= '0;
      grp  <= '0;
      zero <= 1'b1;
    end else if (cen) begin
      pos  <= at_last ? '0 : pos + 1'b1;
      grp  <= (grp == LAST_GRP) ? '0 : grp + 1'b1;
      zero <= at_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int g = 0; g < GROUPS; g++)
        for (int i = 0; i < DEPTH; i++)
          mem[g][i] <= '0;
    end else begin
      for (int g = 0; g < GROUPS; g++) begin
        if (cen && grp == GW'(g)) begin
          for (int i = 0; i < DEPTH-1; i++)
            mem[g][i] <= mem[g][i+1];
          mem[g][DEPTH-1] <= (commit && lat_wr) ? lat_din : mem[g][0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rhy_csr <= '0;
      rhy_oen <= 1'b0;
    end else if (cen) begin
      if (at_last) begin
        rhy_csr <= {rhy_kon[4], rhy_kon[0], rhy_kon[2], rhy_kon[4], rhy_kon[3], rhy_kon[1]};
        rhy_oen <= 1'b0;
      end else begin
        rhy_csr <= {rhy_csr[4:0], rhy_csr[5]};
        if (at_rhy) rhy_oen <= rhy_en;
      end
    end
  end
endmodule

// File: tb/tb_jtopl_reg_chn.sv
module tb_jtopl_reg_chn;
  localparam int NCH = 9;
  localparam int PW  = 4;
  localparam int W   = 10;
  localparam int RP  = 5;

  logic clk = 1'b0;
  logic rst_n, cen, rhy_en;
  logic [4:0] rhy_kon;
  logic [W-1:0] chcfg;
  logic [PW-1:0] ch_idx;
  logic zero, rhy_oen, rhyon_csr;

  jtopl_reg_chn_if #(.PW(PW), .CHCSRW(W)) bus();

  jtopl_reg_chn #(.CHCSRW(W), .GROUPS(3), .DEPTH(3), .RHY_POS(RP), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .rhy_en(rhy_en), .rhy_kon(rhy_kon),
    .cpu(bus), .chcfg(chcfg), .ch_idx(ch_idx), .zero(zero),
    .rhy_oen(rhy_oen), .rhyon_csr(rhyon_csr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Channel-indexed reference model
  int         m_pos;
  logic [W-1:0] m_cfg [NCH];
  logic       m_busy, m_wr, m_ack, m_oen;
  int         m_ch;
  logic [W-1:0] m_din, m_dout;
  logic [5:0] m_csr;

  typedef struct { logic rd; logic [W-1:0] v; } sb_t;
  sb_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic n_ack;
    if (!rst_n) begin
      m_pos = 0; m_busy = 0; m_ack = 0; m_dout = '0; m_csr = '0; m_oen = 0;
      for (int i = 0; i < NCH; i++) m_cfg[i] = '0;
      sb.delete();
      return;
    end
    n_ack = 1'b0;
    if (m_busy) begin
      if (cen && m_pos == m_ch) begin
        if (m_wr) m_cfg[m_ch] = m_din;
        else      m_dout = m_cfg[m_ch];
        m_busy = 0;
        n_ack  = 1'b1;
      end
    end else if ((bus.cpu_wr || bus.cpu_rd) && int'(bus.cpu_ch) < NCH) begin
      m_busy = 1; m_wr = bus.cpu_wr; m_ch = int'(bus.cpu_ch); m_din = bus.cpu_din;
      if (bus.cpu_wr) sb.push_back('{1'b0, bus.cpu_din});
      else            sb.push_back('{1'b1, m_cfg[m_ch]});
    end
    m_ack = n_ack;
    if (cen) begin
      if (m_pos == NCH-1) begin
        m_csr = {rhy_kon[4], rhy_kon[0], rhy_kon[2], rhy_kon[4], rhy_kon[3], rhy_kon[1]};
        m_oen = 0;
      end else begin
        m_csr = {m_csr[4:0], m_csr[5]};
        if (m_pos == RP) m_oen = rhy_en;
      end
      m_pos = (m_pos == NCH-1) ? 0 : m_pos + 1;
    end
  endtask

  task automatic check_outputs();
    sb_t e;
    chk("ch_idx", 32'(ch_idx), 32'(m_pos));
    chk("zero", 32'(zero), 32'(m_pos == 0));
    chk("chcfg", 32'(chcfg), 32'(m_cfg[m_pos]));
    chk("busy", 32'(bus.cpu_busy), 32'(m_busy));
    chk("ack", 32'(bus.cpu_ack), 32'(m_ack));
    chk("dout", 32'(bus.cpu_dout), 32'(m_dout));
    chk("rhy_oen", 32'(rhy_oen), 32'(m_oen));
    chk("rhyon_csr", 32'(rhyon_csr), 32'(m_csr[5]));
    if (bus.cpu_ack === 1'b1) begin
      chk("sb_ack_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.rd) chk("sb_read_data", 32'(bus.cpu_dout), 32'(e.v));
      end
    end
  endtask

  task automatic step(input logic c);
    cen = c;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic wait_idx(input int target);
    for (int k = 0; k < 2*NCH && int'(ch_idx) != target; k++) step(1'b1);
    chk("wait_idx", 32'(ch_idx), 32'(target));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2*NCH+2 && bus.cpu_busy; k++) step(1'b1);
    chk("wait_idle", 32'(bus.cpu_busy), 32'd0);
  endtask

  typedef struct {
    logic wr; logic rd; logic [PW-1:0] ch; logic [W-1:0] din;
    logic accept; logic [W-1:0] dout;
  } vec_t;
  localparam int NV = 10;
  vec_t tbl [NV];

  logic [5:0] rseq;
  int n;
  logic got;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'd7,  10'h155, 1'b1, 10'h000};
    tbl[1] = '{1'b0, 1'b1, 4'd7,  10'h000, 1'b1, 10'h155};
    tbl[2] = '{1'b1, 1'b0, 4'd9,  10'h111, 1'b0, 10'h000};
    tbl[3] = '{1'b0, 1'b1, 4'd15, 10'h000, 1'b0, 10'h000};
    tbl[4] = '{1'b1, 1'b0, 4'd0,  10'h3FF, 1'b1, 10'h000};
    tbl[5] = '{1'b0, 1'b1, 4'd0,  10'h000, 1'b1, 10'h3FF};
    tbl[6] = '{1'b1, 1'b1, 4'd1,  10'h0AA, 1'b1, 10'h000};
    tbl[7] = '{1'b0, 1'b1, 4'd1,  10'h000, 1'b1, 10'h0AA};
    tbl[8] = '{1'b0, 1'b1, 4'd4,  10'h000, 1'b1, 10'h2A5};
    tbl[9] = '{1'b0, 1'b1, 4'd3,  10'h000, 1'b1, 10'h000};

    rst_n = 1'b0; cen = 1'b0; rhy_en = 1'b0; rhy_kon = '0;
    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_ch = '0; bus.cpu_din = '0;
    step(1'b0);
    step(1'b1);
    rst_n = 1'b1;
    chk("rst_ch_idx", 32'(ch_idx), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_chcfg", 32'(chcfg), 32'd0);
    chk("rst_busy", 32'(bus.cpu_busy), 32'd0);

    // Counter sweep
    for (int j = 0; j < NCH; j++) begin
      step(1'b1);
      chk("cnt_idx", 32'(ch_idx), 32'((j+1) % NCH));
    end

    // Write ch 4 captured at pos 0
    bus.cpu_wr = 1'b1; bus.cpu_ch = 4'd4; bus.cpu_din = 10'h2A5;
    step(1'b1);
    bus.cpu_wr = 1'b0;
    n = 0;
    while (bus.cpu_busy && n < 2*NCH) begin step(1'b1); n++; end
    chk("wr4_busy_cens", 32'(n), 32'd4);
    chk("wr4_ack", 32'(bus.cpu_ack), 32'd1);
    step(1'b1);
    chk("wr4_ack_one_cycle", 32'(bus.cpu_ack), 32'd0);
    wait_idx(4);
    chk("wr4_chcfg", 32'(chcfg), 32'h2A5);

    // Table-driven requests
    for (int i = 0; i < NV; i++) begin
      bus.cpu_wr = tbl[i].wr; bus.cpu_rd = tbl[i].rd;
      bus.cpu_ch = tbl[i].ch; bus.cpu_din = tbl[i].din;
      step(1'b1);
      bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
      chk("tbl_accept", 32'(bus.cpu_busy), 32'(tbl[i].accept));
      if (tbl[i].accept) begin
        got = 1'b0;
        for (int k = 0; k < 2*NCH && !got; k++) begin
          if (k == 2 && bus.cpu_busy) begin
            bus.cpu_wr = 1'b1; bus.cpu_ch = 4'd3; bus.cpu_din = 10'h3C3;
          end
          step(1'b1);
          bus.cpu_wr = 1'b0;
          if (bus.cpu_ack) begin
            got = 1'b1;
            if (tbl[i].rd && !tbl[i].wr)
              chk("tbl_dout", 32'(bus.cpu_dout), 32'(tbl[i].dout));
          end
        end
        chk("tbl_ack_seen", 32'(got), 32'd1);
      end
    end

    // Capture while the channel is at head: commits a full revolution later
    wait_idx(2);
    bus.cpu_wr = 1'b1; bus.cpu_ch = 4'd2; bus.cpu_din = 10'h1C7;
    step(1'b1);
    bus.cpu_wr = 1'b0;
    n = 0;
    while (!bus.cpu_ack && n < 2*NCH) begin step(1'b1); n++; end
    chk("head_capture_latency", 32'(n), 32'd9);

    // Rhythm CSR and output enable
    rhy_kon = 5'b10101; rhy_en = 1'b1;
    wait_idx(NCH-1);
    step(1'b1);
    chk("rhy_oen_cleared", 32'(rhy_oen), 32'd0);
    rseq = 6'b111100;
    chk("rhyon_seq0", 32'(rhyon_csr), 32'(rseq[5]));
    for (int j = 1; j < 6; j++) begin
      step(1'b1);
      rseq = {rseq[4:0], rseq[5]};
      chk("rhyon_seq", 32'(rhyon_csr), 32'(rseq[5]));
    end
    chk("rhy_oen_before", 32'(rhy_oen), 32'd0);
    step(1'b1);
    chk("rhy_oen_after", 32'(rhy_oen), 32'd1);

    // Random cen with random requests
    for (int j = 0; j < 80; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.cpu_wr = 1'($urandom_range(0, 1));
        bus.cpu_rd = 1'($urandom_range(0, 1));
        bus.cpu_ch = 4'($urandom_range(0, 10));
        bus.cpu_din = 10'($urandom);
      end
      if (j % 20 == 7) rhy_kon = 5'($urandom);
      step(1'($urandom_range(0, 1)));
      bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
    end

    // Reset with a request outstanding
    wait_idle();
    bus.cpu_wr = 1'b1; bus.cpu_ch = 4'((m_pos + 5) % NCH); bus.cpu_din = 10'h333;
    step(1'b1);
    bus.cpu_wr = 1'b0;
    chk("rst_req_busy", 32'(bus.cpu_busy), 32'd1);
    step(1'b0);
    rst_n = 1'b0;
    step(1'b1);
    step(1'b0);
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(bus.cpu_busy), 32'd0);
    chk("mid_rst_ack", 32'(bus.cpu_ack), 32'd0);
    chk("mid_rst_idx", 32'(ch_idx), 32'd0);
    for (int j = 0; j < 2*NCH; j++) begin
      step(1'b1);
      chk("post_rst_chcfg", 32'(chcfg), 32'd0);
      chk("post_rst_no_ack", 32'(bus.cpu_ack), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
